draw_sprite: RTL and testbench
==============================

# draw_sprite

Parametrised sprite overlay stage for the VGA pixel pipeline. It sits between the background/timing generator and the next draw stage. It overlays a SPRITE_W×SPRITE_H bitmap, read from an external synchronous ROM, at a frame-latched position with optional 2× scaling and colour-key transparency. It delay-matches all timing signals so downstream stages see a coherent stream.

## Interface
- SPRITE_W, 48: sprite width in source pixels (1..256).
- SPRITE_H, 64: sprite height in source pixels (1..256).
- ROM_LATENCY, 1: cycles from pixel_addr to valid rgb_pixel (1..4).
- ADDR_W, 12: pixel_addr width; must satisfy 2^ADDR_W ≥ SPRITE_W*SPRITE_H.
- KEY_COLOR, 12'hF0F: transparent colour value.
- pclk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- hcount_in, vcount_in  in  11  pixel counters from the previous stage.
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing from the previous stage.
- rgb_in  in  12  background colour.
- x_pos, y_pos  in  12  requested top-left corner of the sprite.
- scale_2x  in  1  1 = each source pixel is drawn as a 2×2 block.
- sprite_en  in  1  1 = draw the sprite.
- key_en  in  1  1 = pixels equal to KEY_COLOR show the background.
- rgb_pixel  in  12  ROM data returned for pixel_addr.
- pixel_addr  out  ADDR_W  ROM address, computed as row*SPRITE_W + col.
- hcount_out, vcount_out  out  11  delayed counters.
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  delayed timing.
- rgb_out  out  12  composited colour.

## Operation
- Frame latch:
  - x_pos, y_pos, scale_2x, sprite_en and key_en are copied into active registers only on the rising edge of vblnk_in (vblnk_in=1 while the previous sample was 0).
  - At all other times the active registers hold their values. This makes mid-frame position writes invisible until the next frame.
- Hit test, stage 1:
  - S = 2 if scale_2x is active, else 1.
  - hit = sprite_en & ~hblnk_in & ~vblnk_in & (hcount_in ≥ x_act) & (hcount_in < x_act + SPRITE_W*S) & (vcount_in ≥ y_act) & (vcount_in < y_act + SPRITE_H*S).
  - Comparisons are unsigned on 13 bits, with counters zero-extended. x_act + SPRITE_W*S therefore never wraps, and a sprite extending past the visible area is clipped by blanking.
- Address:
  - col = (hcount_in − x_act) >> (S−1).
  - row = (vcount_in − y_act) >> (S−1).
  - On hit, pixel_addr is registered as row*SPRITE_W + col. Otherwise pixel_addr is registered as 0.
- Compositing, final stage:
  - If the delayed hit is 1, and not (key_en_act & rgb_pixel == KEY_COLOR), then rgb_out = rgb_pixel.
  - Otherwise rgb_out = the delayed rgb_in.
  - key_en_act is the key_en value latched for the current frame.
- Reset: all outputs are 0, pixel_addr is 0, all delay-line contents are 0, and the active registers are 0 (sprite disabled, position 0,0, scale 1×, key off). The vblnk edge detector's previous-sample register is reset to 0.
- Reset asserted mid-frame clears the pipeline within one cycle. The sprite stays disabled until the first vblnk rising edge after reset is released.

## Timing
- Total latency L = ROM_LATENCY + 2 cycles from *_in to *_out, for every timing signal and rgb.
  - With ROM_LATENCY=1, L = 3.
- pixel_addr is valid 1 cycle after the corresponding hcount_in/vcount_in. rgb_pixel is sampled ROM_LATENCY cycles after that.
- hit and rgb_in travel in a delay line of depth ROM_LATENCY+1, followed by the output register.
- The active-register update takes effect on the input sample in the cycle after the vblnk_in rising edge. That sample is blanked, so no visible pixel ever mixes old and new positions.
- There are no stalls and no handshake: the block accepts one pixel every cycle.

## Structure
- The shared package vga_pkg holds:
  - COUNT_W=11, POS_W=12, RGB_W=12.
  - The default KEY_COLOR.
  - A struct or bundle grouping {hcount, vcount, hsync, vsync, hblnk, vblnk}.
- One sub-module, vga_delay: a parametrised (WIDTH, DEPTH) synchronous-reset shift register. It is used for the timing bundle, rgb_in and hit.

## Test plan
- Reset mid-frame:
  - Stimulus: assert rst for 2 cycles during active video.
  - Required: all outputs and pixel_addr are 0 while rst is high. After release with sprite_en=1 but no vblnk edge yet, rgb_out == delayed rgb_in.
- Basic hit, 1× scale, ROM_LATENCY=1:
  - Stimulus: x=100, y=50, sprite_en=1, latched via a vblnk edge.
  - Required: at hcount=100, vcount=50, pixel_addr=0. At hcount=147, vcount=113, pixel_addr=63*48+47=3071. rgb_out = rgb_pixel 3 cycles after each such input.
  - Required: hcount=148 and vcount=114 are misses.
- 2× scale:
  - Stimulus: x=0, y=0, scale_2x=1.
  - Required: hcount 0 and 1 both give col 0. hcount 95 gives col 47. hcount 96 is a miss. vcount 127 gives row 63.
- Frame latch:
  - Stimulus: change x_pos from 100 to 200 mid-frame.
  - Required: the current frame still hits at hcount=100. The next frame, after the vblnk edge, hits at hcount=200.
- Transparency:
  - Stimulus: key_en=1, rgb_pixel=12'hF0F on a hit.
  - Required: rgb_out = background.
  - Required: with key_en=0, rgb_out = 12'hF0F.
- Latency sweep:
  - Stimulus: ROM_LATENCY=3.
  - Required: all outputs are delayed exactly 5 cycles. Timing signals match the inputs bit-for-bit after the delay.
- Clipping:
  - Stimulus: x=4090 (near the 12-bit maximum).
  - Required: no hit anywhere, and no wrap to the left edge.

Source files
------------

// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Package : vga_pkg
// Brief   : Shared widths, default colour key and timing bundle for the VGA
//           pixel pipeline stages.
// Rev     : 1.0 - initial release
// ============================================================================
package vga_pkg;

  localparam int COUNT_W = 11;
  localparam int POS_W   = 12;
  localparam int RGB_W   = 12;

  localparam logic [RGB_W-1:0] KEY_COLOR_DEFAULT = 12'hF0F;

  // Everything a downstream stage needs to know where the beam is
  typedef struct packed {
    logic [COUNT_W-1:0] hcount;
    logic [COUNT_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
  } vga_timing_t;

  localparam int TIMING_W = $bits(vga_timing_t);

endpackage
`default_nettype wire

// File: rtl/vga_delay.sv
`default_nettype none
// ============================================================================
// Module : vga_delay
// Brief  : Fixed-depth shift register with synchronous reset, used to keep
//          side-band data aligned with pipelined pixel processing.
// Rev    : 1.0 - initial release
// ============================================================================
module vga_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_stage [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage captures the incoming word
        always_ff @(posedge clk) begin
          if (rst) r_stage[gi] <= '0;
          else     r_stage[gi] <= i_data;
        end
      end else begin : g_next
        // Later stages shift the word one step along
        always_ff @(posedge clk) begin
          if (rst) r_stage[gi] <= '0;
          else     r_stage[gi] <= r_stage[gi-1];
        end
      end
    end
  endgenerate

  assign o_data = r_stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/draw_sprite.sv
`default_nettype none
// ============================================================================
// Module : draw_sprite
// Brief  : Overlays a ROM-backed sprite on the VGA stream at a frame-latched
//          position, with optional 2x scaling and colour-key transparency.
//          All timing signals are delay-matched to the composited colour.
// Rev    : 1.0 - initial release
// ============================================================================
module draw_sprite
  import vga_pkg::*;
#(
  parameter int              SPRITE_W    = 48,
  parameter int              SPRITE_H    = 64,
  parameter int              ROM_LATENCY = 1,
  parameter int              ADDR_W      = 12,
  parameter logic [RGB_W-1:0] KEY_COLOR  = KEY_COLOR_DEFAULT
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic [COUNT_W-1:0] hcount_in,
  input  logic [COUNT_W-1:0] vcount_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic               hblnk_in,
  input  logic               vblnk_in,
  input  logic [RGB_W-1:0]   rgb_in,
  input  logic [POS_W-1:0]   x_pos,
  input  logic [POS_W-1:0]   y_pos,
  input  logic               scale_2x,
  input  logic               sprite_en,
  input  logic               key_en,
  input  logic [RGB_W-1:0]   rgb_pixel,
  output logic [ADDR_W-1:0]  pixel_addr,
  output logic [COUNT_W-1:0] hcount_out,
  output logic [COUNT_W-1:0] vcount_out,
  output logic               hsync_out,
  output logic               vsync_out,
  output logic               hblnk_out,
  output logic               vblnk_out,
  output logic [RGB_W-1:0]   rgb_out
);

  // One extra bit so that position + span can never wrap
  localparam int EXT_W     = POS_W + 1;
  localparam int PROD_W    = 18;
  localparam int DLY_DEPTH = ROM_LATENCY + 1;

  localparam logic [EXT_W-1:0] C_SPAN_X1 = EXT_W'(SPRITE_W);
  localparam logic [EXT_W-1:0] C_SPAN_X2 = EXT_W'(2 * SPRITE_W);
  localparam logic [EXT_W-1:0] C_SPAN_Y1 = EXT_W'(SPRITE_H);
  localparam logic [EXT_W-1:0] C_SPAN_Y2 = EXT_W'(2 * SPRITE_H);

  logic [POS_W-1:0] r_x_act;
  logic [POS_W-1:0] r_y_act;
  logic             r_scale_act;
  logic             r_en_act;
  logic             r_key_act;
  logic             r_vblnk_prev;
  logic             w_vblnk_rise;

  assign w_vblnk_rise = vblnk_in & ~r_vblnk_prev;

  // Capture sprite controls once per frame, at the start of vertical blanking
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_x_act      <= '0;
      r_y_act      <= '0;
      r_scale_act  <= 1'b0;
      r_en_act     <= 1'b0;
      r_key_act    <= 1'b0;
      r_vblnk_prev <= 1'b0;
    end else begin
      r_vblnk_prev <= vblnk_in;
      if (w_vblnk_rise) begin
        r_x_act     <= x_pos;
        r_y_act     <= y_pos;
        r_scale_act <= scale_2x;
        r_en_act    <= sprite_en;
        r_key_act   <= key_en;
      end
    end
  end

  logic [EXT_W-1:0]  w_h;
  logic [EXT_W-1:0]  w_v;
  logic [EXT_W-1:0]  w_x;
  logic [EXT_W-1:0]  w_y;
  logic [EXT_W-1:0]  w_x_end;
  logic [EXT_W-1:0]  w_y_end;
  logic [EXT_W-1:0]  w_dx;
  logic [EXT_W-1:0]  w_dy;
  logic [EXT_W-1:0]  w_col;
  logic [EXT_W-1:0]  w_row;
  logic              w_hit;
  logic [ADDR_W-1:0] w_addr;

  // Hit test and source-pixel address for the current input sample
  always_comb begin
    w_h     = EXT_W'(hcount_in);
    w_v     = EXT_W'(vcount_in);
    w_x     = EXT_W'(r_x_act);
    w_y     = EXT_W'(r_y_act);
    w_x_end = w_x + (r_scale_act ? C_SPAN_X2 : C_SPAN_X1);
    w_y_end = w_y + (r_scale_act ? C_SPAN_Y2 : C_SPAN_Y1);
    w_hit   = r_en_act & ~hblnk_in & ~vblnk_in &
              (w_h >= w_x) & (w_h < w_x_end) &
              (w_v >= w_y) & (w_v < w_y_end);
    w_dx    = w_h - w_x;
    w_dy    = w_v - w_y;
    w_col   = r_scale_act ? (w_dx >> 1) : w_dx;
    w_row   = r_scale_act ? (w_dy >> 1) : w_dy;
    w_addr  = ADDR_W'(PROD_W'(w_row) * PROD_W'(SPRITE_W) + PROD_W'(w_col));
  end

  logic [ADDR_W-1:0] r_pixel_addr;

  // Present the ROM address one cycle after the sample; misses read address 0
  always_ff @(posedge pclk) begin
    if (rst) r_pixel_addr <= '0;
    else     r_pixel_addr <= w_hit ? w_addr : '0;
  end

  assign pixel_addr = r_pixel_addr;

  vga_timing_t      w_tim_in;
  vga_timing_t      w_tim_dly;
  logic [RGB_W-1:0] w_rgb_dly;
  logic             w_hit_dly;

  assign w_tim_in = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};

  vga_delay #(.WIDTH(TIMING_W), .DEPTH(DLY_DEPTH)) u_dly_timing (
    .clk    (pclk),
    .rst    (rst),
    .i_data (w_tim_in),
    .o_data (w_tim_dly)
  );

  vga_delay #(.WIDTH(RGB_W), .DEPTH(DLY_DEPTH)) u_dly_rgb (
    .clk    (pclk),
    .rst    (rst),
    .i_data (rgb_in),
    .o_data (w_rgb_dly)
  );

  vga_delay #(.WIDTH(1), .DEPTH(DLY_DEPTH)) u_dly_hit (
    .clk    (pclk),
    .rst    (rst),
    .i_data (w_hit),
    .o_data (w_hit_dly)
  );

  logic             w_keyed;
  logic [RGB_W-1:0] w_rgb_next;

  assign w_keyed    = r_key_act & (rgb_pixel == KEY_COLOR);
  assign w_rgb_next = (w_hit_dly & ~w_keyed) ? rgb_pixel : w_rgb_dly;

  vga_timing_t      r_tim_out;
  logic [RGB_W-1:0] r_rgb_out;

  // Output register: composited colour alongside its matching timing
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_tim_out <= '0;
      r_rgb_out <= '0;
    end else begin
      r_tim_out <= w_tim_dly;
      r_rgb_out <= w_rgb_next;
    end
  end

  assign hcount_out = r_tim_out.hcount;
  assign vcount_out = r_tim_out.vcount;
  assign hsync_out  = r_tim_out.hsync;
  assign vsync_out  = r_tim_out.vsync;
  assign hblnk_out  = r_tim_out.hblnk;
  assign vblnk_out  = r_tim_out.vblnk;
  assign rgb_out    = r_rgb_out;

endmodule
`default_nettype wire

// File: tb/tb_draw_sprite.sv
`default_nettype none
// ============================================================================
// Module : tb_draw_sprite
// Brief  : Scoreboard bench for draw_sprite; two instances (ROM latency 1
//          and 3) share one stimulus stream and one reference model.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_draw_sprite;

  localparam int          SW  = 48;
  localparam int          SH  = 64;
  localparam logic [11:0] KEY = 12'hF0F;
  localparam int          L1  = 3;
  localparam int          L3  = 5;

  typedef struct {
    logic        rst;
    logic [10:0] h;
    logic [10:0] v;
    logic        hs, vs, hb, vb;
    logic [11:0] exp_rgb;
    int          addr;
    logic        dchk;
    int          daddr;
  } ent_t;

  ent_t q1[$];
  ent_t q3[$];

  logic        pclk = 1'b0;
  logic        rst;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in, x_pos, y_pos;
  logic        scale_2x, sprite_en, key_en;

  logic [11:0] rp1, pa1, rgb_out1;
  logic [10:0] hc1, vc1;
  logic        hs1, vs1, hb1, vb1;

  logic [11:0] rp3_pipe [3];
  logic [11:0] rp3, pa3, rgb_out3;
  logic [10:0] hc3, vc3;
  logic        hs3, vs3, hb3, vb3;

  int n_run  = 0;
  int n_fail = 0;

  // Model state: controls latched for the current frame
  int a_x = 0, a_y = 0;
  bit a_sc = 0, a_en = 0, a_key = 0, a_prev = 0;
  bit d_en = 0;
  int d_val = 0;

  always #5 pclk = ~pclk;

  function automatic logic [11:0] rom_fn(int a);
    if (a % 5 == 2) return KEY;
    return 12'((a * 37 + 11) & 32'hFFF);
  endfunction

  // Behavioural synchronous ROMs of the two latencies
  always @(posedge pclk) rp1 <= rom_fn(int'(pa1));
  always @(posedge pclk) begin
    rp3_pipe[0] <= rom_fn(int'(pa3));
    rp3_pipe[1] <= rp3_pipe[0];
    rp3_pipe[2] <= rp3_pipe[1];
  end
  assign rp3 = rp3_pipe[2];

  draw_sprite #(.SPRITE_W(SW), .SPRITE_H(SH), .ROM_LATENCY(1), .ADDR_W(12), .KEY_COLOR(KEY)) dut1 (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .x_pos(x_pos), .y_pos(y_pos), .scale_2x(scale_2x),
    .sprite_en(sprite_en), .key_en(key_en), .rgb_pixel(rp1), .pixel_addr(pa1),
    .hcount_out(hc1), .vcount_out(vc1), .hsync_out(hs1), .vsync_out(vs1),
    .hblnk_out(hb1), .vblnk_out(vb1), .rgb_out(rgb_out1));

  draw_sprite #(.SPRITE_W(SW), .SPRITE_H(SH), .ROM_LATENCY(3), .ADDR_W(12), .KEY_COLOR(KEY)) dut3 (
    .pclk(pclk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .rgb_in(rgb_in), .x_pos(x_pos), .y_pos(y_pos), .scale_2x(scale_2x),
    .sprite_en(sprite_en), .key_en(key_en), .rgb_pixel(rp3), .pixel_addr(pa3),
    .hcount_out(hc3), .vcount_out(vc3), .hsync_out(hs3), .vsync_out(vs3),
    .hblnk_out(hb3), .vblnk_out(vb3), .rgb_out(rgb_out3));

  // Compare one instance against the oldest queued sample and the address of the newest
  task automatic chk(string nm, int lat, input ent_t q[$], logic [37:0] got_o, logic [11:0] got_a);
    bit          zero = 0;
    logic [37:0] exp_o;
    logic [11:0] exp_a;
    for (int i = 0; i < lat; i++) if (q[i].rst) zero = 1;
    exp_o = zero ? 38'd0 : {q[0].h, q[0].v, q[0].hs, q[0].vs, q[0].hb, q[0].vb, q[0].exp_rgb};
    n_run++;
    if (got_o !== exp_o) begin
      n_fail++;
      $display("FAIL %s outputs got=%h exp=%h (h=%0d v=%0d)", nm, got_o, exp_o, q[0].h, q[0].v);
    end
    exp_a = q[lat-1].rst ? 12'd0 : 12'(q[lat-1].addr);
    n_run++;
    if (got_a !== exp_a) begin
      n_fail++;
      $display("FAIL %s pixel_addr got=%0d exp=%0d", nm, got_a, exp_a);
    end
    if (q[lat-1].dchk && !q[lat-1].rst) begin
      n_run++;
      if (got_a !== 12'(q[lat-1].daddr)) begin
        n_fail++;
        $display("FAIL %s directed_addr got=%0d exp=%0d", nm, got_a, q[lat-1].daddr);
      end
    end
  endtask

  // Monitor: away from the active edge, pop one expected entry per instance
  always @(negedge pclk) begin
    if (q1.size() == L1 + 1) begin
      chk("L1", L1, q1, {hc1, vc1, hs1, vs1, hb1, vb1, rgb_out1}, pa1);
      void'(q1.pop_front());
    end
    if (q3.size() == L3 + 1) begin
      chk("L3", L3, q3, {hc3, vc3, hs3, vs3, hb3, vb3, rgb_out3}, pa3);
      void'(q3.pop_front());
    end
  end

  // Reference model for the current sample, then advance one clock
  task automatic step();
    ent_t e;
    int   s, hh, vv;
    bit   hit;
    logic [11:0] pix;
    s  = a_sc ? 2 : 1;
    hh = int'(hcount_in);
    vv = int'(vcount_in);
    hit = a_en && !hblnk_in && !vblnk_in && hh >= a_x && hh < a_x + SW * s &&
          vv >= a_y && vv < a_y + SH * s;
    e.rst = rst; e.h = hcount_in; e.v = vcount_in;
    e.hs = hsync_in; e.vs = vsync_in; e.hb = hblnk_in; e.vb = vblnk_in;
    e.addr = hit ? ((vv - a_y) / s) * SW + (hh - a_x) / s : 0;
    pix = rom_fn(e.addr);
    e.exp_rgb = (hit && !(a_key && pix == KEY)) ? pix : rgb_in;
    e.dchk = d_en; e.daddr = d_val;
    q1.push_back(e);
    q3.push_back(e);
    if (rst) begin
      a_x = 0; a_y = 0; a_sc = 0; a_en = 0; a_key = 0; a_prev = 0;
    end else begin
      if (vblnk_in && !a_prev) begin
        a_x = int'(x_pos); a_y = int'(y_pos); a_sc = scale_2x; a_en = sprite_en; a_key = key_en;
      end
      a_prev = vblnk_in;
    end
    @(posedge pclk);
    #1;
  endtask

  // One visible pixel, optionally with a fixed expected ROM address
  task automatic px(int h, int v, bit dc = 0, int da = 0);
    hcount_in = 11'(h); vcount_in = 11'(v);
    hblnk_in = 0; vblnk_in = 0;
    hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    rgb_in = 12'($urandom);
    d_en = dc; d_val = da;
    step();
    d_en = 0;
  endtask

  // Blanked run-in followed by a vblnk pulse that latches the current controls
  task automatic new_frame();
    for (int i = 0; i < 8; i++) begin
      hcount_in = 11'($urandom); vcount_in = 11'($urandom);
      hblnk_in = 1; vblnk_in = (i >= 5);
      hsync_in = 1'($urandom); vsync_in = 1'($urandom);
      rgb_in = 12'($urandom);
      step();
    end
  endtask

  task automatic set_ctl(int x, int y, bit sc, bit en, bit k);
    x_pos = 12'(x); y_pos = 12'(y); scale_2x = sc; sprite_en = en; key_en = k;
  endtask

  initial begin
    rst = 1;
    hcount_in = 0; vcount_in = 0; hsync_in = 0; vsync_in = 0;
    hblnk_in = 0; vblnk_in = 0; rgb_in = 0;
    set_ctl(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step();
    rst = 0;

    // Enabled but not yet latched: background only
    set_ctl(100, 50, 0, 1, 0);
    px(100, 50, 1, 0); px(120, 60, 1, 0); px(101, 51);

    // Basic 1x hit and its boundaries
    new_frame();
    px(100, 50, 1, 0); px(147, 113, 1, 3071); px(148, 113, 1, 0);
    px(147, 114, 1, 0); px(99, 50, 1, 0); px(100, 49, 1, 0);
    for (int i = 0; i < 20; i++) px(100 + i, 70, 1, 20 * SW + i);

    // Mid-frame position change stays invisible until the next frame
    x_pos = 200;
    px(100, 60, 1, 480); px(200, 60, 1, 0);
    new_frame();
    px(200, 60, 1, 480); px(100, 60, 1, 0);

    // Reset during active video, then no sprite until a vblnk edge
    for (int i = 0; i < 4; i++) px(200 + i, 60);
    rst = 1; px(201, 61); px(202, 61); rst = 0;
    for (int i = 0; i < 6; i++) px(200 + i, 60, 1, 0);

    // 2x scale
    set_ctl(0, 0, 1, 1, 0);
    new_frame();
    px(0, 0, 1, 0); px(1, 0, 1, 0); px(95, 0, 1, 47); px(96, 0, 1, 0);
    px(0, 127, 1, 3024); px(0, 128, 1, 0); px(95, 127, 1, 3071); px(3, 5, 1, 2 * SW + 1);

    // Colour key on, then off, over the same pixels
    set_ctl(0, 0, 0, 1, 1);
    new_frame();
    for (int i = 0; i < 12; i++) px(i, 0, 1, i);
    set_ctl(0, 0, 0, 1, 0);
    new_frame();
    for (int i = 0; i < 12; i++) px(i, 0, 1, i);

    // Clipping near the top of the position range: no wrap to the left edge
    set_ctl(4090, 0, 0, 1, 0);
    new_frame();
    for (int h = 0; h < 2048; h += 3) px(h, 5, 1, 0);

    // Randomised frames
    for (int f = 0; f < 30; f++) begin
      int x, y;
      x = (f % 6 == 5) ? int'($urandom_range(4000, 4095)) : int'($urandom_range(0, 1950));
      y = int'($urandom_range(0, 1000));
      set_ctl(x, y, 1'($urandom), ($urandom % 4) != 0, 1'($urandom));
      new_frame();
      for (int i = 0; i < 80; i++) begin
        int h, v;
        h = (x > 2047) ? int'($urandom_range(0, 2047)) : x + int'($urandom_range(0, 200)) - 4;
        v = y + int'($urandom_range(0, 140)) - 4;
        if (i == 40) x_pos = 12'($urandom);
        px(h, v);
        if ($urandom % 10 == 0) begin
          hblnk_in = 1; step();
        end
      end
    end

    for (int i = 0; i < 10; i++) px(0, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
